cntry_car_detector: RTL and testbench

Vehicle-detection front end for the country-road approach of the traffic signal controller. It conditions two raw inductive-loop inputs, an advance loop (arrival) and a stop-line loop (departure), and keeps a saturating count of queued vehicles. It produces the `CAR_ON_CNTRY_RD` request that the controller consumes, and uses the controller's `CNTRY_SIG` to track when the queue is being served.

---
 rtl/cntry_car_detector.sv | 211 +++++++++++++++++++++
 tb/tb_cntry_car_detector.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cntry_car_detector.sv
`default_nettype none
// ============================================================================
// Module   : cntry_car_detector
// Purpose  : Country-road vehicle detection front end. Synchronizes and
//            debounces the advance (arrival) and stop-line (departure) loops,
//            keeps a saturating queue count and raises a registered request
//            to the signal controller.
// Option   : CNTRY_SENSOR_FAULT_EN adds stop-line stuck detection with a
//            SENSOR_FAULT flag and a failsafe forced request.
// Revision : 1.0  initial release
// ============================================================================
module cntry_car_detector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
`ifdef CNTRY_SENSOR_FAULT_EN
    ,
    parameter int STUCK_CYCLES    = 64
`endif
) (
    input  logic             CLK,
    input  logic             CLEAR,
    input  logic             LOOP_ARR,
    input  logic             LOOP_DEP,
    input  logic [1:0]       CNTRY_SIG,
    output logic             CAR_ON_CNTRY_RD,
    output logic             ARRIVAL,
    output logic [CNT_W-1:0] CAR_COUNT
`ifdef CNTRY_SENSOR_FAULT_EN
    ,
    output logic             SENSOR_FAULT
`endif
);

    localparam int             c_db_w    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};
    localparam logic [1:0]        c_green   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    // Index 0 is the advance loop, index 1 is the stop-line loop.
    logic [1:0] w_raw;
    logic [1:0] w_flip;
    logic [1:0] w_level;

    assign w_raw = {LOOP_DEP, LOOP_ARR};

    generate
        for (genvar i = 0; i < 2; i++) begin : g_loop
            logic              r_sync1;
            logic              r_sync2;
            logic              r_filt;
            logic [c_db_w-1:0] r_db_cnt;
            logic              w_toggle;

            // Filtered level flips on the cycle the mismatch count would reach the limit.
            assign w_toggle   = (r_sync2 != r_filt) && (r_db_cnt == c_db_last);
            assign w_flip[i]  = w_toggle;
            assign w_level[i] = r_filt;

            // Two-flop synchronizer followed by the mismatch-run debounce counter.
            always_ff @(posedge CLK) begin
                if (CLEAR) begin
                    r_sync1  <= 1'b0;
                    r_sync2  <= 1'b0;
                    r_filt   <= 1'b0;
                    r_db_cnt <= '0;
                end else begin
                    r_sync1 <= w_raw[i];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_filt) begin
                        r_db_cnt <= '0;
                    end else if (w_toggle) begin
                        r_filt   <= ~r_filt;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + c_db_w'(1);
                    end
                end
            end
        end
    endgenerate

    // Only a rising advance loop and a falling stop-line loop are vehicle events.
    logic w_arrival;
    logic w_departure;
    assign w_arrival   = w_flip[0] & ~w_level[0];
    assign w_departure = w_flip[1] &  w_level[1];

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_next_count;
    logic             w_has_cars;
    logic             w_green;

    // Saturating queue count; simultaneous arrival and departure cancel out.
    always_comb begin
        w_next_count = r_count;
        if (w_arrival && !w_departure) begin
            if (r_count != c_cnt_max) w_next_count = r_count + CNT_W'(1);
        end else if (w_departure && !w_arrival) begin
            if (r_count != '0) w_next_count = r_count - CNT_W'(1);
        end
    end

    assign w_has_cars = (w_next_count != '0);
    assign w_green    = (CNTRY_SIG == c_green);

    logic w_fault_next;

`ifdef CNTRY_SENSOR_FAULT_EN
    localparam int                 c_occ_w = $clog2(STUCK_CYCLES + 1);
    localparam logic [c_occ_w-1:0] c_stuck = c_occ_w'(STUCK_CYCLES);

    logic [c_occ_w-1:0] r_occ;
    logic [c_occ_w-1:0] w_occ_next;
    logic               r_fault;

    // Stop-line occupancy counter; the departure that ends occupancy releases the fault.
    always_comb begin
        w_occ_next   = r_occ;
        w_fault_next = r_fault;
        if (w_departure) begin
            w_occ_next   = '0;
            w_fault_next = 1'b0;
        end else if (w_level[1] && (r_occ != c_stuck)) begin
            w_occ_next = r_occ + c_occ_w'(1);
            if (w_occ_next == c_stuck) w_fault_next = 1'b1;
        end
    end

    // Occupancy and fault registers.
    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            r_occ   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_occ   <= w_occ_next;
            r_fault <= w_fault_next;
        end
    end

    assign SENSOR_FAULT = r_fault;
`else
    assign w_fault_next = 1'b0;
`endif

    state_t r_state;
    logic   r_req;
    logic   r_arrival;

    // Request FSM with count and outputs registered on the same edge as the event.
    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            r_state   <= ST_IDLE;
            r_req     <= 1'b0;
            r_arrival <= 1'b0;
            r_count   <= '0;
        end else begin
            r_arrival <= w_arrival;
            r_count   <= w_next_count;
            case (r_state)
                ST_IDLE: begin
                    if (w_has_cars) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                    end else begin
                        r_req   <= w_fault_next;
                    end
                end
                ST_REQ: begin
                    if (w_green) begin
                        r_state <= ST_SERVE;
                        r_req   <= w_has_cars | w_fault_next;
                    end else if (!w_has_cars) begin
                        r_state <= ST_IDLE;
                        r_req   <= w_fault_next;
                    end else begin
                        r_req   <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (!w_green) begin
                        if (w_has_cars) begin
                            r_state <= ST_REQ;
                            r_req   <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_req   <= w_fault_next;
                        end
                    end else begin
                        r_req <= w_has_cars | w_fault_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= w_fault_next;
                end
            endcase
        end
    end

    assign CAR_ON_CNTRY_RD = r_req;
    assign ARRIVAL         = r_arrival;
    assign CAR_COUNT       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cntry_car_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_cntry_car_detector
// Purpose  : Self-checking bench for cntry_car_detector. Table of directed
//            steps (inputs held for N cycles, expected request, count and
//            number of ARRIVAL pulses) plus hand sequences for reset,
//            exact event timing and the optional CNTRY_SENSOR_FAULT_EN path.
// Revision : 1.0  initial release
// ============================================================================
module tb_cntry_car_detector;

    localparam logic [1:0] c_red    = 2'd0;
    localparam logic [1:0] c_yellow = 2'd1;
    localparam logic [1:0] c_green  = 2'd2;

    logic       clk;
    logic       clear;
    logic       loop_arr;
    logic       loop_dep;
    logic [1:0] cntry_sig;
    logic       car_on_cntry_rd;
    logic       arrival;
    logic [3:0] car_count;
`ifdef CNTRY_SENSOR_FAULT_EN
    logic       sensor_fault;
`endif

    cntry_car_detector dut (
        .CLK             (clk),
        .CLEAR           (clear),
        .LOOP_ARR        (loop_arr),
        .LOOP_DEP        (loop_dep),
        .CNTRY_SIG       (cntry_sig),
        .CAR_ON_CNTRY_RD (car_on_cntry_rd),
        .ARRIVAL         (arrival),
        .CAR_COUNT       (car_count)
`ifdef CNTRY_SENSOR_FAULT_EN
        ,
        .SENSOR_FAULT    (sensor_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       arr;
        logic       dep;
        logic [1:0] sig;
        int         cyc;
        logic       req;
        int         cnt;
        int         pulses;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void add(input logic clr, input logic arr, input logic dep,
                                input logic [1:0] sig, input int cyc, input logic req,
                                input int cnt, input int pulses);
        vec_t v;
        v.clr = clr; v.arr = arr; v.dep = dep; v.sig = sig; v.cyc = cyc;
        v.req = req; v.cnt = cnt; v.pulses = pulses;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else            n_pass++;
    endtask

    // Drive inputs at a negedge, run cyc rising edges, count ARRIVAL pulses at negedges.
    task automatic step(input logic clr, input logic arr, input logic dep,
                        input logic [1:0] sig, input int cyc, output int pulses);
        clear = clr; loop_arr = arr; loop_dep = dep; cntry_sig = sig;
        pulses = 0;
        for (int c = 0; c < cyc; c++) begin
            @(negedge clk);
            pulses += int'(arrival);
        end
    endtask

    initial begin
        int p;
        int c;

        clear = 1'b1; loop_arr = 1'b0; loop_dep = 1'b0; cntry_sig = c_red;
        @(negedge clk);

        // Reset held with loops toggling: everything stays at zero.
        for (int i = 0; i < 5; i++) begin
            loop_arr = (i % 2 == 0);
            loop_dep = (i % 2 != 0);
            @(negedge clk);
            check($sformatf("reset%0d_req", i), int'(car_on_cntry_rd), 0);
            check($sformatf("reset%0d_arrival", i), int'(arrival), 0);
            check($sformatf("reset%0d_count", i), int'(car_count), 0);
        end
        clear = 1'b0; loop_arr = 1'b0; loop_dep = 1'b0;

        // Two-cycle glitch on the advance loop is filtered out.
        step(1'b0, 1'b1, 1'b0, c_red, 2, p);
        c = p;
        step(1'b0, 1'b0, 1'b0, c_red, 8, p);
        check("glitch_pulses", c + p, 0);
        check("glitch_count", int'(car_count), 0);
        check("glitch_req", int'(car_on_cntry_rd), 0);

        // Arrival timing: raw rise first sampled at edge k, event at k+5.
        loop_arr = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            check($sformatf("arr_timing_e%0d", e), int'(arrival), (e == 5) ? 1 : 0);
            if (e == 4) begin
                check("arr_pre_count", int'(car_count), 0);
                check("arr_pre_req", int'(car_on_cntry_rd), 0);
            end
            if (e == 5) begin
                check("arr_edge_count", int'(car_count), 1);
                check("arr_edge_req", int'(car_on_cntry_rd), 1);
            end
        end

        // Table: arrival release, service and departure timing.
        add(0, 0, 0, c_red,    8, 1, 1, 0);
        add(0, 0, 0, c_green,  4, 1, 1, 0);
        add(0, 0, 1, c_green,  8, 1, 1, 0);
        add(0, 0, 0, c_green,  5, 1, 1, 0);
        add(0, 0, 0, c_green,  1, 0, 0, 0);
        add(0, 0, 0, c_yellow, 1, 0, 0, 0);
        add(0, 0, 0, c_green,  3, 0, 0, 0);
        // Sixteen arrivals saturate at 15, the last one still pulses.
        for (int i = 0; i < 16; i++) begin
            add(0, 1, 0, c_red, 8, 1, (i + 1 > 15) ? 15 : i + 1, 1);
            add(0, 0, 0, c_red, 8, 1, (i + 1 > 15) ? 15 : i + 1, 0);
        end
        // Five departures, then simultaneous arrival and departure, then fifteen more.
        c = 15;
        for (int j = 1; j <= 20; j++) begin
            add(0, 0, 1, c_red, 8, (c != 0), c, 0);
            c = (c > 0) ? c - 1 : 0;
            add(0, 0, 0, c_red, 8, (c != 0), c, 0);
            if (j == 5) begin
                add(0, 0, 1, c_red, 8, 1, c, 0);
                add(0, 1, 0, c_red, 8, 1, c, 1);
                add(0, 0, 0, c_red, 8, 1, c, 0);
            end
        end
        // Count of 2 through GREEN then YELLOW keeps the request up.
        add(0, 1, 0, c_red,    8, 1, 1, 1);
        add(0, 0, 0, c_red,    8, 1, 1, 0);
        add(0, 1, 0, c_red,    8, 1, 2, 1);
        add(0, 0, 0, c_red,    8, 1, 2, 0);
        add(0, 0, 0, c_green,  2, 1, 2, 0);
        add(0, 0, 0, c_yellow, 1, 1, 2, 0);
        add(0, 0, 0, 2'd3,     3, 1, 2, 0);
        // Mid-operation clear discards an in-progress debounce.
        add(0, 1, 0, c_red,    4, 1, 2, 0);
        add(1, 1, 0, c_red,    1, 0, 0, 0);
        add(0, 1, 0, c_red,    5, 0, 0, 0);
        add(0, 1, 0, c_red,    1, 1, 1, 1);
        add(0, 0, 0, c_red,    8, 1, 1, 0);
        add(1, 0, 0, c_red,    1, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].clr, tbl[i].arr, tbl[i].dep, tbl[i].sig, tbl[i].cyc, p);
            check($sformatf("row%0d_req", i), int'(car_on_cntry_rd), int'(tbl[i].req));
            check($sformatf("row%0d_count", i), int'(car_count), tbl[i].cnt);
            check($sformatf("row%0d_pulses", i), p, tbl[i].pulses);
        end

`ifdef CNTRY_SENSOR_FAULT_EN
        // Stuck stop-line with an empty queue forces the failsafe request.
        check("fault_reset", int'(sensor_fault), 0);
        step(1'b0, 1'b0, 1'b1, c_red, 40, p);
        check("fault_early_flag", int'(sensor_fault), 0);
        check("fault_early_req", int'(car_on_cntry_rd), 0);
        step(1'b0, 1'b0, 1'b1, c_red, 40, p);
        check("fault_flag", int'(sensor_fault), 1);
        check("fault_req", int'(car_on_cntry_rd), 1);
        check("fault_count", int'(car_count), 0);
        step(1'b0, 1'b0, 1'b0, c_red, 5, p);
        check("fault_hold_flag", int'(sensor_fault), 1);
        check("fault_hold_req", int'(car_on_cntry_rd), 1);
        step(1'b0, 1'b0, 1'b0, c_red, 1, p);
        check("fault_release_flag", int'(sensor_fault), 0);
        check("fault_release_req", int'(car_on_cntry_rd), 0);
        check("fault_release_count", int'(car_count), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
